// File: rtl/coin_entry_conditioner.sv
// ---------------------------------------------------------------------------
// coin_entry_conditioner
//
// Input stage of the vending-machine controller. It synchronises the raw board
// switches and the KEY1 commit button, and debounces KEY1 on both press and
// release. Once per clean press it samples the coin/credit/clear switches and
// classifies them into a single coin event. The event is held on a
// valid/ready handshake until the controller takes it.
//
// Ports
//   clock_i        24 MHz board clock. All state changes on the rising edge.
//   reset_i        synchronous reset, active high
//   sw_i[9:0]      raw switches: 0 nickel, 1 dime, 2 quarter, 3 dollar,
//                  4 credit, 8 clear, 9 report (5-7 ignored)
//   key_i[3:0]     raw pushbuttons, active low. Only key_i[1] is used.
//   evt_valid_o    a coin event is pending
//   evt_ready_i    the controller takes the event this cycle
//   evt_kind_o     0 NONE, 1 NICKEL, 2 DIME, 3 QUARTER, 4 DOLLAR,
//                  5 CREDIT, 6 CLEAR, 7 MULTI
//   evt_cents_o    value of the event in cents (0 for NONE/CLEAR/MULTI)
//   report_mode_o  synchronised sw_i[9] level
//   overrun_o      sticky: a press was dropped while an event was pending
// ---------------------------------------------------------------------------
//  state        | meaning
//  -------------+------------------------------------------------------------
//  IDLE         | key released and stable; waiting for a press
//  PRESS_WAIT   | key seen low; counting stable-low cycles
//  HELD         | press accepted and event issued; waiting for release
//  RELEASE_WAIT | key seen high; counting stable-high cycles
// ---------------------------------------------------------------------------
module coin_entry_conditioner #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [9:0] sw_i,
    input  logic [3:0] key_i,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [2:0] evt_kind_o,
    output logic [6:0] evt_cents_o,
    output logic       report_mode_o,
    output logic       overrun_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        K_NONE    = 3'd0,
        K_NICKEL  = 3'd1,
        K_DIME    = 3'd2,
        K_QUARTER = 3'd3,
        K_DOLLAR  = 3'd4,
        K_CREDIT  = 3'd5,
        K_CLEAR   = 3'd6,
        K_MULTI   = 3'd7
    } kind_t;

    // Only the switches that matter are synchronised: {sw9, sw8, sw4..sw0}.
    logic [6:0] sw_s1_q;
    logic [6:0] sw_s2_q;
    logic       key_s1_q;
    logic       key_s2_q;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          evt_valid_q;
    kind_t         evt_kind_q;
    logic [6:0]    evt_cents_q;
    logic          overrun_q;

    logic       unused_inputs;
    assign unused_inputs = ^{key_i[3:2], key_i[0], sw_i[7:5]};

    // ------------------------------------------------------------------
    // Two-flop synchronisers. The key flops come out of reset at the
    // released level, so a reset never looks like a press.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
        end else begin
            sw_s1_q  <= {sw_i[9], sw_i[8], sw_i[4:0]};
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= key_i[1];
            key_s2_q <= key_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Classification of the synchronised switches
    // ------------------------------------------------------------------
    logic [5:0] coin_bits;
    logic       coin_multi;
    kind_t      cls_kind_d;
    logic [6:0] cls_cents_d;

    assign coin_bits = {sw_s2_q[5], sw_s2_q[4:0]};
    // More than one bit is set exactly when clearing the lowest set bit
    // leaves something behind.
    assign coin_multi = |(coin_bits & (coin_bits - 6'd1));

    always_comb begin
        cls_kind_d = K_NONE;
        if (coin_multi) begin
            cls_kind_d = K_MULTI;
        end else begin
            unique case (coin_bits)
                6'b000001: cls_kind_d = K_NICKEL;
                6'b000010: cls_kind_d = K_DIME;
                6'b000100: cls_kind_d = K_QUARTER;
                6'b001000: cls_kind_d = K_DOLLAR;
                6'b010000: cls_kind_d = K_CREDIT;
                6'b100000: cls_kind_d = K_CLEAR;
                default:   cls_kind_d = K_NONE;
            endcase
        end
    end

    always_comb begin
        cls_cents_d = 7'd0;
        case (cls_kind_d)
            K_NICKEL:  cls_cents_d = 7'd5;
            K_DIME:    cls_cents_d = 7'd10;
            K_QUARTER: cls_cents_d = 7'd25;
            K_DOLLAR:  cls_cents_d = 7'd100;
            K_CREDIT:  cls_cents_d = 7'd35;
            default:   cls_cents_d = 7'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Debounce FSM and event handshake
    // ------------------------------------------------------------------
    logic issue;
    assign issue = (state_q == PRESS_WAIT) && !key_s2_q && (cnt_q == CNT_MAX);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_kind_q  <= K_NONE;
            evt_cents_q <= 7'd0;
            overrun_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!key_s2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (key_s2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_s2_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase

            // An event the controller is taking this cycle frees the slot
            // for a press that completes on the same cycle.
            if (issue) begin
                if (evt_valid_q && !evt_ready_i) begin
                    overrun_q <= 1'b1;
                end else begin
                    evt_valid_q <= 1'b1;
                    evt_kind_q  <= cls_kind_d;
                    evt_cents_q <= cls_cents_d;
                end
            end else if (evt_valid_q && evt_ready_i) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    assign evt_valid_o   = evt_valid_q;
    assign evt_kind_o    = evt_kind_q;
    assign evt_cents_o   = evt_cents_q;
    assign overrun_o     = overrun_q;
    assign report_mode_o = sw_s2_q[6];

endmodule

// File: tb/tb_coin_entry_conditioner.sv
module tb_coin_entry_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] sw;
    logic [3:0] key;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_kind;
    logic [6:0] evt_cents;
    logic       report_mode;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coin_entry_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .sw_i          (sw),
        .key_i         (key),
        .evt_valid_o   (evt_valid),
        .evt_ready_i   (evt_ready),
        .evt_kind_o    (evt_kind),
        .evt_cents_o   (evt_cents),
        .report_mode_o (report_mode),
        .overrun_o     (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        key       = 4'hF;
        sw        = 10'h000;
        evt_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Press KEY1 cleanly with the given switches and report the first event seen.
    task automatic do_press(input logic [9:0] s, output bit found,
                            output logic [2:0] k, output logic [6:0] c);
        sw = s;
        repeat (3) tick();
        key[1] = 1'b0;
        found = 0;
        k = 3'd0;
        c = 7'd0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (evt_valid) begin
                found = 1;
                k = evt_kind;
                c = evt_cents;
            end
        end
        key[1] = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        total++; if (evt_kind !== 3'd0) begin bad++; $display("FAIL reset_kind: got %0d want 0", evt_kind); end
        total++; if (evt_cents !== 7'd0) begin bad++; $display("FAIL reset_cents: got %0d want 0", evt_cents); end
        total++; if (report_mode !== 1'b0) begin bad++; $display("FAIL reset_report: got %b want 0", report_mode); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_latency();
        int pulses = 0;
        int first = -1;
        logic [2:0] k = 3'd0;
        logic [6:0] c = 7'd0;
        evt_ready = 1'b1;
        sw = 10'h004;
        repeat (3) tick();
        key[1] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (evt_valid) begin
                pulses++;
                if (first < 0) begin first = i; k = evt_kind; c = evt_cents; end
            end
        end
        key[1] = 1'b1;
        repeat (12) tick();
        // First sample is edge E; valid rises after edge E+6.
        total++; if (pulses !== 1) begin bad++; $display("FAIL latency_pulses: got %0d want 1", pulses); end
        total++; if (first !== 7) begin bad++; $display("FAIL latency_cycle: got %0d want 7", first); end
        total++; if (k !== 3'd3) begin bad++; $display("FAIL latency_kind: got %0d want 3", k); end
        total++; if (c !== 7'd25) begin bad++; $display("FAIL latency_cents: got %0d want 25", c); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        logic [2:0] k = 3'd0;
        logic [6:0] c = 7'd0;
        evt_ready = 1'b1;
        sw = 10'h008;
        repeat (3) tick();
        for (int i = 0; i < 12; i++) begin
            key[1] = ((i / 2) % 2) == 1;
            tick();
            if (evt_valid) pulses++;
        end
        key[1] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (evt_valid) begin pulses++; k = evt_kind; c = evt_cents; end
        end
        key[1] = 1'b1;
        repeat (12) tick();
        total++; if (pulses !== 1) begin bad++; $display("FAIL bounce_pulses: got %0d want 1", pulses); end
        total++; if (k !== 3'd4) begin bad++; $display("FAIL bounce_kind: got %0d want 4", k); end
        total++; if (c !== 7'd100) begin bad++; $display("FAIL bounce_cents: got %0d want 100", c); end
    endtask

    task automatic test_classify();
        logic [9:0] sws   [6] = '{10'h003, 10'h000, 10'h100, 10'h0E2, 10'h201, 10'h010};
        logic [2:0] kinds [6] = '{3'd7, 3'd0, 3'd6, 3'd2, 3'd1, 3'd5};
        logic [6:0] cents [6] = '{7'd0, 7'd0, 7'd0, 7'd10, 7'd5, 7'd35};
        bit found;
        logic [2:0] k;
        logic [6:0] c;
        evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_press(sws[i], found, k, c);
            total++; if (!found) begin bad++; $display("FAIL classify_found[%0d]: got none want event", i); end
            total++; if (k !== kinds[i]) begin bad++; $display("FAIL classify_kind[%0d]: got %0d want %0d", i, k, kinds[i]); end
            total++; if (c !== cents[i]) begin bad++; $display("FAIL classify_cents[%0d]: got %0d want %0d", i, c, cents[i]); end
        end
    endtask

    task automatic test_overrun();
        bit found;
        logic [2:0] k;
        logic [6:0] c;
        int pulses = 0;
        evt_ready = 1'b0;
        do_press(10'h010, found, k, c);
        total++; if (!found) begin bad++; $display("FAIL ovr_first_found: got none want event"); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", overrun); end
        sw = 10'h001;
        repeat (3) tick();
        key[1] = 1'b0;
        repeat (12) tick();
        key[1] = 1'b1;
        repeat (12) tick();
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold_valid: got %b want 1", evt_valid); end
        total++; if (evt_kind !== 3'd5) begin bad++; $display("FAIL ovr_hold_kind: got %0d want 5", evt_kind); end
        total++; if (evt_cents !== 7'd35) begin bad++; $display("FAIL ovr_hold_cents: got %0d want 35", evt_cents); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        evt_ready = 1'b1;
        tick();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovr_transfer_valid: got %b want 0", evt_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (evt_valid) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL ovr_extra_events: got %0d want 0", pulses); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_long_hold();
        int pulses = 0;
        int late = 0;
        logic [2:0] k = 3'd0;
        evt_ready = 1'b1;
        sw = 10'h002;
        repeat (3) tick();
        key[1] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (evt_valid) begin pulses++; k = evt_kind; end
        end
        key[1] = 1'b1;
        tick();
        key[1] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (evt_valid) late++;
        end
        key[1] = 1'b1;
        repeat (15) tick();
        total++; if (pulses !== 1) begin bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
        total++; if (k !== 3'd2) begin bad++; $display("FAIL hold_kind: got %0d want 2", k); end
        total++; if (late !== 0) begin bad++; $display("FAIL hold_release_bounce: got %0d want 0", late); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL hold_overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        evt_ready = 1'b1;
        sw = 10'h004;
        repeat (3) tick();
        key[1] = 1'b0;
        repeat (5) tick();          // PRESS_WAIT with count 3
        reset = 1'b1;
        key = 4'hF;
        tick();
        reset = 1'b0;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", evt_valid); end
        total++; if (evt_kind !== 3'd0) begin bad++; $display("FAIL mid_kind: got %0d want 0", evt_kind); end
        total++; if (evt_cents !== 7'd0) begin bad++; $display("FAIL mid_cents: got %0d want 0", evt_cents); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_overrun: got %b want 0", overrun); end
        total++; if (report_mode !== 1'b0) begin bad++; $display("FAIL mid_report: got %b want 0", report_mode); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (evt_valid) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_event: got %0d want 0", pulses); end
        sw = 10'h200;
        tick();
        total++; if (report_mode !== 1'b0) begin bad++; $display("FAIL report_1clk: got %b want 0", report_mode); end
        tick();
        total++; if (report_mode !== 1'b1) begin bad++; $display("FAIL report_2clk: got %b want 1", report_mode); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        sw        = 10'h000;
        key       = 4'hF;
        evt_ready = 1'b0;
        test_reset();
        test_latency();
        test_bounce();
        test_classify();
        test_overrun();
        test_long_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
